// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey plus rounds 1-10
// over one shared combinational round datapath, one round per clock.

module subbytes (
    input  logic [127:0] state,
    output logic [127:0] out
);
    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            logic [7:0]  b;
            logic [10:0] off;
            assign b   = state[8*gi +: 8];
            // Entry b sits at bit offset (255 - b) * 8, i.e. {~b, 3'b000}.
            assign off = {~b, 3'b000};
            assign out[8*gi +: 8] = SBOX[off +: 8];
        end
    endgenerate
endmodule

module shiftrows (
    input  logic [127:0] state,
    output logic [127:0] out
);
    // Byte n = row (n % 4), column (n / 4); byte 0 occupies [127:120].
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
            assign out[127-8*gi -: 8] = state[127-8*SRC -: 8];
        end
    endgenerate
endmodule

module mixcolumns (
    input  logic [127:0] state,
    output logic [127:0] out
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = state[127-32*gi -: 8];
            assign a1 = state[119-32*gi -: 8];
            assign a2 = state[111-32*gi -: 8];
            assign a3 = state[103-32*gi -: 8];
            assign out[127-32*gi -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            assign out[119-32*gi -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            assign out[111-32*gi -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            assign out[103-32*gi -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
    endgenerate
endmodule

module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic [3:0]   key_round,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic [3:0]   key_round_q, key_round_d;

    logic [127:0] sb_out, sr_out, mc_out, round_out;

    subbytes   u_subbytes   (.state(st_q),   .out(sb_out));
    shiftrows  u_shiftrows  (.state(sb_out), .out(sr_out));
    mixcolumns u_mixcolumns (.state(sr_out), .out(mc_out));

    // The last round skips MixColumns; everything else shares one path.
    assign round_out = ((state_q == S_FINAL) ? sr_out : mc_out) ^ round_key;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = data_in ^ round_key;
                    rnd_d   = 4'd1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                st_d  = round_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q >= 4'd9) begin
                    rnd_d   = 4'd10;
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                st_d    = round_out;
                rnd_d   = 4'd0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                rnd_d   = 4'd0;
                st_d    = '0;
            end
        endcase

        // Outputs are decoded from the next state so they leave the flops glitch-free.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_ROUND) || (state_d == S_FINAL);
        key_round_d = busy_d ? rnd_d : 4'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rnd_q       <= 4'd0;
            st_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            key_round_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            key_round_q <= key_round_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign key_round = key_round_q;
    assign data_out  = st_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 C.1, zero-key vector, key index
// sequence, backpressure, back-to-back, asynchronous reset and idle behaviour.

module tb_aes_round_ctrl;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] CT_B  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] data_in = '0;
    logic [3:0]   key_round;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] data_out;
    logic         busy;

    logic [127:0] rk_a [0:10];
    logic [127:0] rk_b [0:10];
    logic         key_sel = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    aes_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_round (key_round),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Key store: combinational lookup by the requested round index.
    always_comb begin
        round_key = '0;
        if (key_round <= 4'd10) begin
            round_key = key_sel ? rk_b[key_round] : rk_a[key_round];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse and the affine map.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] b;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])}
                    ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the DUT in IDLE; leaves it one sample into DONE.
    task automatic run_block(input string name, input logic [127:0] pt,
                             input logic [127:0] ct, input bit chk_rk10);
        data_in  = pt;
        in_valid = 1'b1;
        check({name, "_accept"}, {in_ready, key_round}, {1'b1, 4'd0});
        tick();
        in_valid = 1'b0;
        data_in  = '0;
        for (int i = 1; i <= 10; i++) begin
            check({name, "_round"}, {busy, out_valid, key_round}, {1'b1, 1'b0, 4'(i)});
            if (chk_rk10 && i == 10) check({name, "_rk10"}, round_key, RK10);
            tick();
        end
        check({name, "_done"}, {out_valid, busy, in_ready, key_round}, {1'b1, 1'b0, 1'b0, 4'd0});
        check({name, "_ct"}, data_out, ct);
        $display("block %s pt=%h ct=%h", name, pt, data_out);
    endtask

    initial begin
        logic [1407:0] ka;
        logic [1407:0] kb;
        int  acc2;
        bit  got1;
        bit  got2;
        bit  prev_ready;

        ka = expand(KEY_A);
        kb = expand(128'h0);
        for (int r = 0; r <= 10; r++) begin
            rk_a[r] = ka[1407-128*r -: 128];
            rk_b[r] = kb[1407-128*r -: 128];
        end

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("reset_ctl", {in_ready, out_valid, busy, key_round}, {1'b1, 1'b0, 1'b0, 4'd0});
        check("reset_data", data_out, 128'h0);
        tick();
        rst = 1'b0;
        tick();

        // FIPS-197 C.1 with out_ready high.
        out_ready = 1'b1;
        run_block("c1", PT_A, CT_A, 1'b1);
        tick();
        check("c1_release", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});

        // Idle guard.
        for (int k = 0; k < 50; k++) begin
            check("idle", {in_ready, busy, out_valid, key_round}, {1'b1, 1'b0, 1'b0, 4'd0});
            tick();
        end

        // Backpressure: DONE held 20 cycles, stray in_valid ignored.
        out_ready = 1'b0;
        run_block("bp", PT_A, CT_A, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                in_valid = 1'b1;
                data_in  = 128'hdeadbeef_00000000_12345678_9abcdef0;
            end
            if (k == 6) begin
                in_valid = 1'b0;
                data_in  = '0;
            end
            check("bp_hold_ctl", {out_valid, in_ready, busy}, {1'b1, 1'b0, 1'b0});
            check("bp_hold_data", data_out, CT_A);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});
        check("bp_data", data_out, CT_A);

        // Back-to-back: in_valid held high, second block uses the all-zero key.
        key_sel  = 1'b0;
        data_in  = PT_A;
        in_valid = 1'b1;
        tick();
        data_in    = '0;
        acc2       = -1;
        got1       = 1'b0;
        got2       = 1'b0;
        prev_ready = 1'b0;
        for (int k = 1; k <= 30 && !got2; k++) begin
            tick();
            if (out_valid && !got1) begin
                check("b2b_ct1", data_out, CT_A);
                $display("block b2b1 pt=%h ct=%h", PT_A, data_out);
                key_sel = 1'b1;
                got1    = 1'b1;
            end
            if (prev_ready && busy && acc2 < 0) acc2 = k;
            if (acc2 > 0 && out_valid) begin
                check("b2b_ct2", data_out, CT_B);
                check("b2b_lat2", 32'(k - acc2), 32'd10);
                $display("block b2b2 pt=%h ct=%h", 128'h0, data_out);
                in_valid = 1'b0;
                got2     = 1'b1;
            end
            prev_ready = in_ready;
        end
        in_valid = 1'b0;
        check("b2b_done", {got1, got2}, 2'b11);
        check("b2b_accept_gap", 32'(acc2), 32'd12);
        tick();
        key_sel = 1'b0;

        // Asynchronous reset at round 5, then a fresh run.
        data_in  = PT_A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data_in  = '0;
        repeat (4) tick();
        check("mid_round5", {busy, key_round}, {1'b1, 4'd5});
        #1 rst = 1'b1;
        #1;
        check("mid_reset_ctl", {in_ready, out_valid, busy, key_round}, {1'b1, 1'b0, 1'b0, 4'd0});
        check("mid_reset_data", data_out, 128'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_reset", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});
        run_block("c1_again", PT_A, CT_A, 1'b1);
        tick();
        check("final_idle", {in_ready, out_valid}, {1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption sequencer: accepts one 128-bit block, runs the initial AddRoundKey plus rounds 1–10 over a single shared round datapath, one round per clock, and presents the ciphertext on a valid/ready output. It sits between the block-level input buffer and the output stage. It drives the existing combinational `subbytes`, `shiftrows` and `mixcolumns` modules, each with ports `state`/`out`, 128 bits wide. It also indexes the external round-key store.

## Interface

- No parameters (AES-128 only; Nr = 10 fixed).
- `clk`  input  1  — single clock; all state updates on rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `in_valid`  input  1  — plaintext on `data_in` is valid.
- `in_ready`  output  1  — block can accept a plaintext this cycle.
- `data_in`  input  128  — plaintext. Byte 0 is `[127:120]`, column-major per FIPS-197, matching `mixcolumns`.
- `key_round`  output  4  — round-key index requested this cycle (0–10).
- `round_key`  input  128  — round key for `key_round`, valid combinationally in the same cycle.
- `out_valid`  output  1  — ciphertext on `data_out` is valid.
- `out_ready`  input  1  — downstream accepts ciphertext.
- `data_out`  output  128  — ciphertext (state register).
- `busy`  output  1  — high in ROUND and FINAL.

## Operation

- FSM states: IDLE, ROUND, FINAL, DONE. A 4-bit round counter `rnd` and a 128-bit state register `st`.
- **IDLE**
  - `in_ready`=1, `key_round`=0.
  - On `in_valid && in_ready`: `st <= data_in ^ round_key`, `rnd <= 1`, go to ROUND.
- **ROUND** (rnd 1..9)
  - `key_round`=`rnd`.
  - `st <= mixcolumns(shiftrows(subbytes(st))) ^ round_key`, `rnd <= rnd+1`.
  - When `rnd`=9, go to FINAL (`rnd` becomes 10).
- **FINAL** (rnd 10)
  - `key_round`=10.
  - `st <= shiftrows(subbytes(st)) ^ round_key`, mixcolumns bypassed.
  - Go to DONE, `rnd <= 0`.
- **DONE**
  - `out_valid`=1, `key_round`=0, `st` held stable.
  - On `out_ready`: go to IDLE.
- `in_ready` is high only in IDLE. No new block is accepted in DONE, even when `out_ready`=1 in that same cycle.
- `in_valid` and `data_in` are ignored outside IDLE.
- `out_valid` is high only in DONE.
- `rnd` never exceeds 10. Illegal FSM encodings return to IDLE on the next edge with `st` cleared.
- The round datapath is purely combinational: one 128-bit path, one `mixcolumns` instance, bypass mux for FINAL.

## Timing

- **Reset values** (asserted asynchronously, regardless of clock):
  - FSM=IDLE, `rnd`=0, `st`=0.
  - Outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `data_out`=0, `key_round`=0.
- **Reset mid-operation:** the current block is dropped, no `out_valid` is produced, and the block is ready again on the first edge after deassertion.
- **Latency:** accept edge E0; rounds 1–9 on E1–E9; final round on E10; `out_valid` rises after E10, i.e. 10 cycles after the accept edge.
- **Throughput:** at best one block per 12 cycles (accept, 10 rounds, 1 DONE cycle with `out_ready`=1, then back in IDLE). With `out_ready` held high, `in_ready` returns one cycle after `out_valid` rises.
- **Backpressure:** DONE is held indefinitely while `out_ready`=0; `data_out` and `out_valid` are stable throughout.
- **Key store:** must present `round_key` for `key_round` combinationally within the same cycle. `key_round` is a registered-state decode, so it is glitch-free at the clock edge.
- **Critical path:** `st` → subbytes → shiftrows → mixcolumns → XOR → `st`.

## Test plan

- **FIPS-197 C.1 vector**
  - Stimulus: key `000102030405060708090a0b0c0d0e0f` (bench models key expansion indexed by `key_round`); `data_in`=`00112233445566778899aabbccddeeff` with `in_valid` for one cycle.
  - Required: `out_valid` exactly 10 cycles after accept; `data_out`=`69c4e0d86a7b0430d8cdb78070b4c55a`.
- **Round-index sequence**
  - Required: `key_round` reads 0 at accept, then 1,2,…,10 on consecutive cycles, then 0 in DONE.
  - Required: the bench sees round-10 key `13111d7fe3944a17f307a78b4d2b30c5` requested in the FINAL cycle.
- **Backpressure**
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Required: `data_out` constant at the ciphertext, `in_ready`=0, and a second `in_valid` pulse is ignored. Releasing `out_ready` gives `in_ready`=1 on the next cycle.
- **Back-to-back**
  - Stimulus: `in_valid` held high with two blocks queued, `out_ready`=1.
  - Required: second accept occurs 12 cycles after the first; both ciphertexts are correct. Second block is `data_in`=0, key 0, ciphertext `66e94bd4ef8a2c3b884cfa59ca342b2e`.
- **Reset mid-round**
  - Stimulus: assert `rst` asynchronously at round 5.
  - Required: all outputs at reset values immediately. After release, a fresh C.1 run produces the correct ciphertext with no stale `out_valid`.
- **Idle guard**
  - Stimulus: `in_valid`=0 for 50 cycles.
  - Required: FSM stays in IDLE, `busy`=0, `out_valid`=0, `key_round`=0.
